rx_frame_ctrl: RTL and testbench

- Control unit for the serial receiver. It sequences the bit-period timer and the bit counter, both flex-counter style: count 1..rollover_val, then wrap to 1.
- Detects the start bit, samples each bit at mid-period, assembles the data byte, checks the stop bit, and presents the byte to the host with a ready/read handshake plus error flags.
- Sits between the input synchronizer and the receive FIFO/host interface.

---
 rtl/rx_frame_ctrl_if.sv | 26 ++
 rtl/rx_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_rx_frame_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_ctrl_if.sv
// rtl/rx_frame_ctrl_if.sv - receiver control line, configuration and host handshake bundle
interface rx_frame_ctrl_if #(
    parameter int PERIOD_BITS = 4,
    parameter int MAX_DATA    = 8
);
    logic                   serial_in;
    logic [PERIOD_BITS-1:0] bit_period;
    logic [3:0]             data_size;
    logic                   data_read;
    logic [MAX_DATA-1:0]    rx_data;
    logic                   data_ready;
    logic                   framing_error;
    logic                   overrun_error;
    logic                   shift_strobe;
    logic                   busy;

    modport master (
        output serial_in, bit_period, data_size, data_read,
        input  rx_data, data_ready, framing_error, overrun_error, shift_strobe, busy
    );

    modport slave (
        input  serial_in, bit_period, data_size, data_read,
        output rx_data, data_ready, framing_error, overrun_error, shift_strobe, busy
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - serial receiver frame sequencer with mid-bit sampling and host handshake
module rx_frame_ctrl #(
    parameter int PERIOD_BITS = 4,
    parameter int MAX_DATA    = 8
) (
    input logic          clk,
    input logic          n_rst,
    rx_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_DATA);

    state_t                 state;
    logic                   prev_line;
    logic [PERIOD_BITS-1:0] timer;
    logic [PERIOD_BITS-1:0] per_l;
    logic [3:0]             size_l;
    logic [3:0]             bit_cnt;
    logic [MAX_DATA-1:0]    shift_reg;
    logic [MAX_DATA-1:0]    rx_data_r;
    logic                   data_ready_r;
    logic                   framing_error_r;
    logic                   overrun_error_r;

    logic [PERIOD_BITS-1:0] half;
    logic [PERIOD_BITS-1:0] timer_next;
    logic [3:0]             size_clamped;
    logic [3:0]             shamt;
    logic                   sample;
    logic                   start_detect;

    assign half         = per_l >> 1;
    assign sample       = (timer == half);
    assign timer_next   = (timer == per_l) ? PERIOD_BITS'(1) : timer + PERIOD_BITS'(1);
    assign size_clamped = (bus.data_size == 4'd0 || bus.data_size > MAX_L) ? MAX_L : bus.data_size;
    // Bits arrive at the MSB, so a short frame sits in the top size_l bits until aligned.
    assign shamt        = MAX_L - size_l;
    assign start_detect = (state == IDLE) && !bus.serial_in && prev_line;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            prev_line       <= 1'b1;
            timer           <= '0;
            per_l           <= '0;
            size_l          <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            rx_data_r       <= '0;
            data_ready_r    <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_error_r <= 1'b0;
        end else begin
            prev_line <= bus.serial_in;
            if (bus.data_read) begin
                data_ready_r    <= 1'b0;
                overrun_error_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_detect) begin
                        per_l           <= bus.bit_period;
                        size_l          <= size_clamped;
                        timer           <= '0;
                        framing_error_r <= 1'b0;
                        state           <= START;
                    end
                end
                START: begin
                    timer <= timer_next;
                    if (sample) begin
                        if (!bus.serial_in) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    timer <= timer_next;
                    if (sample) begin
                        shift_reg <= {bus.serial_in, shift_reg[MAX_DATA-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt + 4'd1 == size_l)
                            state <= STOP;
                    end
                end
                STOP: begin
                    timer <= timer_next;
                    if (sample) begin
                        if (bus.serial_in) begin
                            state <= LOAD;
                        end else begin
                            framing_error_r <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                LOAD: begin
                    // Placed after the read clear so a same-cycle read cannot drop the new word.
                    rx_data_r    <= shift_reg >> shamt;
                    data_ready_r <= 1'b1;
                    if (data_ready_r && !bus.data_read)
                        overrun_error_r <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rx_data_r;
    assign bus.data_ready    = data_ready_r;
    assign bus.framing_error = framing_error_r;
    assign bus.overrun_error = overrun_error_r;
    assign bus.shift_strobe  = (state == DATA) && sample;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed vector bench for rx_frame_ctrl
module tb_rx_frame_ctrl;
    localparam int PB = 4;
    localparam int MD = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rx_frame_ctrl_if #(.PERIOD_BITS(PB), .MAX_DATA(MD)) bus();

    rx_frame_ctrl #(.PERIOD_BITS(PB), .MAX_DATA(MD)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: totals, first strobe after busy rises, and spacing extremes.
    int   strobe_total = 0;
    int   first_strobe_cyc = 0;
    int   busy_rise_cyc = 0;
    int   last_strobe_cyc = 0;
    int   min_gap = 0;
    int   max_gap = 0;
    bit   first_pend = 1'b0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        busy_q <= bus.busy;
        if (bus.busy === 1'b1 && busy_q !== 1'b1) begin
            busy_rise_cyc <= cyc;
            first_pend    <= 1'b1;
        end
        if (bus.shift_strobe === 1'b1) begin
            strobe_total    <= strobe_total + 1;
            last_strobe_cyc <= cyc;
            if (first_pend) begin
                first_strobe_cyc <= cyc;
                first_pend       <= 1'b0;
                min_gap          <= 1000;
                max_gap          <= 0;
            end else begin
                if (cyc - last_strobe_cyc < min_gap) min_gap <= cyc - last_strobe_cyc;
                if (cyc - last_strobe_cyc > max_gap) max_gap <= cyc - last_strobe_cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
    endtask

    task automatic send_frame(input int per, input int nbits, input logic [7:0] data,
                              input bit stop, input bit rd_in_load);
        logic [7:0] d;
        d = data;
        bus.serial_in = 1'b0;
        repeat (per) tick();
        for (int j = 0; j < nbits; j++) begin
            bus.serial_in = d[j];
            repeat (per) tick();
        end
        for (int i = 0; i < per + 4; i++) begin
            bus.serial_in = (i < per) ? stop : 1'b1;
            bus.data_read = rd_in_load && (i == per / 2 + 2);
            tick();
        end
        bus.data_read = 1'b0;
        bus.serial_in = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (bus.busy !== 1'b0) check({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        int         per;
        int         dsize;
        int         nbits;
        logic [7:0] data;
        bit         stop;
        bit         pre_read;
        bit         rd_in_load;
        bit         post_read;
        logic [7:0] exp_data;
        bit         exp_ready;
        bit         exp_fe;
        bit         exp_oe;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int s0;
        string nm;

        vecs[0]  = '{10, 8,  8, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4,  5,  5, 8'h0D, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10, 8,  8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{10, 8,  8, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{10, 8,  8, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{6,  8,  8, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{6,  8,  8, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{7,  0,  8, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{5,  12, 8, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3,  1,  1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{15, 3,  3, 8'hFD, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0};

        bus.serial_in  = 1'b1;
        bus.bit_period = 4'd10;
        bus.data_size  = 4'd8;
        bus.data_read  = 1'b0;
        n_rst          = 1'b0;
        repeat (3) tick();
        check("reset_rx_data", 32'(bus.rx_data), 32'h0);
        check("reset_ready", 32'(bus.data_ready), 32'd0);
        check("reset_fe", 32'(bus.framing_error), 32'd0);
        check("reset_oe", 32'(bus.overrun_error), 32'd0);
        check("reset_strobe", 32'(bus.shift_strobe), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        n_rst = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 11; i++) begin
            nm = $sformatf("vec%0d", i);
            bus.bit_period = PB'(vecs[i].per);
            bus.data_size  = 4'(vecs[i].dsize);
            if (vecs[i].pre_read) pulse_read();
            tick();
            s0 = strobe_total;
            send_frame(vecs[i].per, vecs[i].nbits, vecs[i].data, vecs[i].stop, vecs[i].rd_in_load);
            wait_idle(nm);
            check({nm, "_rx_data"}, 32'(bus.rx_data), 32'(vecs[i].exp_data));
            check({nm, "_ready"}, 32'(bus.data_ready), 32'(vecs[i].exp_ready));
            check({nm, "_fe"}, 32'(bus.framing_error), 32'(vecs[i].exp_fe));
            check({nm, "_oe"}, 32'(bus.overrun_error), 32'(vecs[i].exp_oe));
            check({nm, "_strobes"}, 32'(strobe_total - s0), 32'(vecs[i].nbits));
            if (i == 0) begin
                check("vec0_first_strobe_delay", 32'(first_strobe_cyc - busy_rise_cyc), 32'd15);
                check("vec0_min_gap", 32'(min_gap), 32'd10);
                check("vec0_max_gap", 32'(max_gap), 32'd10);
            end
            if (vecs[i].post_read) begin
                pulse_read();
                check({nm, "_read_ready"}, 32'(bus.data_ready), 32'd0);
                check({nm, "_read_oe"}, 32'(bus.overrun_error), 32'd0);
            end
        end

        // Short low glitch is rejected at the start sample point.
        bus.bit_period = 4'd10;
        bus.data_size  = 4'd8;
        s0 = strobe_total;
        bus.serial_in = 1'b0;
        repeat (2) tick();
        bus.serial_in = 1'b1;
        tick();
        check("glitch_busy_high", 32'(bus.busy), 32'd1);
        repeat (10) tick();
        check("glitch_busy_low", 32'(bus.busy), 32'd0);
        check("glitch_strobes", 32'(strobe_total - s0), 32'd0);
        check("glitch_ready", 32'(bus.data_ready), 32'd1);
        check("glitch_fe", 32'(bus.framing_error), 32'd0);

        // Reset asserted while bit 3 of 0x5A is on the line.
        s0 = strobe_total;
        bus.serial_in = 1'b0;
        repeat (10) tick();
        bus.serial_in = 1'b0; repeat (10) tick();
        bus.serial_in = 1'b1; repeat (10) tick();
        bus.serial_in = 1'b0; repeat (10) tick();
        bus.serial_in = 1'b1; repeat (3) tick();
        check("midrst_strobes_before", 32'(strobe_total - s0), 32'd3);
        n_rst = 1'b0;
        #1;
        check("midrst_rx_data", 32'(bus.rx_data), 32'h0);
        check("midrst_ready", 32'(bus.data_ready), 32'd0);
        check("midrst_fe", 32'(bus.framing_error), 32'd0);
        check("midrst_oe", 32'(bus.overrun_error), 32'd0);
        check("midrst_strobe", 32'(bus.shift_strobe), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        n_rst = 1'b1;
        bus.serial_in = 1'b1;
        repeat (3) tick();
        s0 = strobe_total;
        send_frame(10, 8, 8'h5A, 1'b1, 1'b0);
        wait_idle("post_rst");
        check("post_rst_rx_data", 32'(bus.rx_data), 32'h5A);
        check("post_rst_ready", 32'(bus.data_ready), 32'd1);
        check("post_rst_oe", 32'(bus.overrun_error), 32'd0);
        check("post_rst_strobes", 32'(strobe_total - s0), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
